// File: rtl/mapper_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mapper_ram_arbiter_pkg
// Description : Shared register-map constants (RAM depth and word-address
//               width) and the grant-owner enumeration used by the mapper
//               RAM arbiter and its result FIFO.
// Contents    : c_MAP_ADDR_W  - default RAM word-address width
//               c_MAP_DEPTH   - number of valid RAM words
//               owner_e       - which requester owns the RAM this cycle
// Revision    : 1.0 - initial release
// ============================================================================
package mapper_ram_arbiter_pkg;

    localparam int c_MAP_ADDR_W = 8;
    localparam int c_MAP_DEPTH  = 240;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_BUS  = 2'd1,
        OWNER_DP   = 2'd2
    } owner_e;

endpackage : mapper_ram_arbiter_pkg
`default_nettype wire

// File: rtl/mapper_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mapper_result_fifo
// Description : Two-entry fall-through result FIFO. When empty, pushed data is
//               presented on the output in the same cycle so a lookup result
//               appears one cycle after its grant; if the consumer is not
//               ready the word is captured and held stable.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               i_push/i_push_data - write strobe and data
//               i_ready            - consumer accepts o_data this cycle
//               o_valid/o_data     - head-of-queue result (o_data 0 when idle)
//               o_count            - stored entries (0..2), excludes bypass
// Revision    : 1.0 - initial release
// ============================================================================
module mapper_result_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem_q [2];
    logic [DATA_W-1:0] w_mem_d [2];
    logic              r_wr_ptr_q;
    logic              w_wr_ptr_d;
    logic              r_rd_ptr_q;
    logic              w_rd_ptr_d;
    logic [1:0]        r_count_q;
    logic [1:0]        w_count_d;

    logic w_empty;
    logic w_pop;
    logic w_bypass;
    logic w_write;
    logic w_read;

    always_comb begin
        w_empty = (r_count_q == 2'd0);
        o_valid = !w_empty || i_push;
        if (!w_empty) begin
            o_data = r_mem_q[r_rd_ptr_q];
        end else if (i_push) begin
            o_data = i_push_data;
        end else begin
            o_data = '0;
        end
        o_count = r_count_q;

        w_pop    = o_valid && i_ready;
        // Empty queue, push and pop together: the word flows straight through
        // and storage/occupancy are left untouched.
        w_bypass = w_empty && i_push && w_pop;
        w_write  = i_push && !w_bypass;
        w_read   = w_pop && !w_empty;

        w_mem_d = r_mem_q;
        if (w_write) begin
            w_mem_d[r_wr_ptr_q] = i_push_data;
        end
        w_wr_ptr_d = r_wr_ptr_q ^ w_write;
        w_rd_ptr_d = r_rd_ptr_q ^ w_read;
        w_count_d  = r_count_q + {1'b0, w_write} - {1'b0, w_read};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_q    <= '{default: '0};
            r_wr_ptr_q <= 1'b0;
            r_rd_ptr_q <= 1'b0;
            r_count_q  <= 2'd0;
        end else begin
            r_mem_q    <= w_mem_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

endmodule : mapper_result_fifo
`default_nettype wire

// File: rtl/mapper_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mapper_ram_arbiter
// Description : Arbitrates a single-port RAM between a bus master and a
//               datapath lookup stream. The bus has priority, but after
//               MAX_BUS_RUN consecutive bus grants with the datapath waiting
//               the datapath is served. Lookup results go through a 2-entry
//               fall-through FIFO; addresses >= DEPTH are granted without
//               touching the RAM and read back as zero.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               bus_req/addr/wdata/wen     - bus request (wen==0 => read)
//               bus_gnt/rvalid/rdata/err   - bus grant, read return, range error
//               dp_addr_valid/dp_addr      - lookup request
//               dp_addr_ready              - lookup accepted
//               dp_data_valid/dp_data      - lookup result
//               dp_data_ready              - result consumer ready
//               ram_en/addr/wdata/wen      - RAM command (combinational)
//               ram_rdata                  - RAM read data, 1-cycle latency
//               conflict_count             - contention counter (optional)
// Options     : define MAPPER_ARB_STATS_EN to add the 16-bit saturating
//               conflict_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module mapper_ram_arbiter
    import mapper_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = c_MAP_ADDR_W,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = c_MAP_DEPTH,
    parameter int MAX_BUS_RUN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bus_req,
    input  logic [ADDR_W-1:0]   bus_addr,
    input  logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W/8-1:0] bus_wen,
    output logic                bus_gnt,
    output logic                bus_rvalid,
    output logic [DATA_W-1:0]   bus_rdata,
    output logic                bus_err,
    input  logic                dp_addr_valid,
    input  logic [ADDR_W-1:0]   dp_addr,
    output logic                dp_addr_ready,
    output logic                dp_data_valid,
    output logic [DATA_W-1:0]   dp_data,
    input  logic                dp_data_ready,
    output logic                ram_en,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_wen,
    input  logic [DATA_W-1:0]   ram_rdata
`ifdef MAPPER_ARB_STATS_EN
    ,
    output logic [15:0]         conflict_count
`endif
);

    localparam int                c_RUN_W     = (MAX_BUS_RUN < 1) ? 1 : $clog2(MAX_BUS_RUN + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX  = c_RUN_W'(MAX_BUS_RUN);
    localparam logic [ADDR_W:0]   c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    owner_e              w_owner;
    logic                w_bus_in_range;
    logic                w_dp_in_range;
    logic                w_dp_credit;
    logic                w_dp_ok;
    logic [1:0]          w_fifo_count;
    logic [DATA_W-1:0]   w_push_data;

    logic [c_RUN_W-1:0]  r_run_cnt_q;
    logic [c_RUN_W-1:0]  w_run_cnt_d;
    logic                r_dp_inflight_q;
    logic                w_dp_inflight_d;
    logic                r_dp_oor_q;
    logic                w_dp_oor_d;
    logic                r_bus_rd_q;
    logic                w_bus_rd_d;
    logic                r_bus_oor_q;
    logic                w_bus_oor_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_bus_in_range = ({1'b0, bus_addr} < c_DEPTH_EXT);
        w_dp_in_range  = ({1'b0, dp_addr} < c_DEPTH_EXT);
        // A lookup may only launch if its result is guaranteed a FIFO slot:
        // stored results plus the read already in flight must leave room.
        w_dp_credit    = (({1'b0, w_fifo_count} + {2'b00, r_dp_inflight_q}) < 3'd2);
        w_dp_ok        = dp_addr_valid && w_dp_credit;

        w_owner = OWNER_NONE;
        if (rst_n) begin
            if (w_dp_ok && (!bus_req || (r_run_cnt_q >= c_RUN_MAX))) begin
                w_owner = OWNER_DP;
            end else if (bus_req) begin
                w_owner = OWNER_BUS;
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant and RAM command outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus_gnt       = (w_owner == OWNER_BUS);
        dp_addr_ready = (w_owner == OWNER_DP);
        bus_err       = bus_gnt && !w_bus_in_range;

        ram_en    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wen   = '0;
        case (w_owner)
            OWNER_BUS: begin
                ram_en    = w_bus_in_range;
                ram_addr  = bus_addr;
                ram_wdata = bus_wdata;
                ram_wen   = w_bus_in_range ? bus_wen : '0;
            end
            OWNER_DP: begin
                ram_en   = w_dp_in_range;
                ram_addr = dp_addr;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state: run counter and in-flight read tracking
    // ------------------------------------------------------------------
    always_comb begin
        w_dp_inflight_d = (w_owner == OWNER_DP);
        w_dp_oor_d      = (w_owner == OWNER_DP) && !w_dp_in_range;
        w_bus_rd_d      = (w_owner == OWNER_BUS) && (bus_wen == '0);
        w_bus_oor_d     = (w_owner == OWNER_BUS) && !w_bus_in_range;

        w_run_cnt_d = r_run_cnt_q;
        if ((w_owner == OWNER_DP) || !dp_addr_valid) begin
            w_run_cnt_d = '0;
        end else if ((w_owner == OWNER_BUS) && (r_run_cnt_q != c_RUN_MAX)) begin
            w_run_cnt_d = r_run_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt_q     <= '0;
            r_dp_inflight_q <= 1'b0;
            r_dp_oor_q      <= 1'b0;
            r_bus_rd_q      <= 1'b0;
            r_bus_oor_q     <= 1'b0;
        end else begin
            r_run_cnt_q     <= w_run_cnt_d;
            r_dp_inflight_q <= w_dp_inflight_d;
            r_dp_oor_q      <= w_dp_oor_d;
            r_bus_rd_q      <= w_bus_rd_d;
            r_bus_oor_q     <= w_bus_oor_d;
        end
    end

    // ------------------------------------------------------------------
    // Read returns
    // ------------------------------------------------------------------
    always_comb begin
        // Out-of-range reads never enabled the RAM, so substitute zero.
        w_push_data = r_dp_oor_q ? '0 : ram_rdata;
        bus_rvalid  = r_bus_rd_q;
        bus_rdata   = (r_bus_rd_q && !r_bus_oor_q) ? ram_rdata : '0;
    end

    mapper_result_fifo #(
        .DATA_W (DATA_W)
    ) u_result_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_dp_inflight_q),
        .i_push_data (w_push_data),
        .i_ready     (dp_data_ready),
        .o_valid     (dp_data_valid),
        .o_data      (dp_data),
        .o_count     (w_fifo_count)
    );

`ifdef MAPPER_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Contention statistics: both sides pending means exactly one loses.
    // ------------------------------------------------------------------
    logic        w_conflict;
    logic [15:0] r_conflict_cnt_q;
    logic [15:0] w_conflict_cnt_d;

    always_comb begin
        w_conflict       = bus_req && dp_addr_valid && (w_owner != OWNER_NONE);
        w_conflict_cnt_d = r_conflict_cnt_q;
        if (w_conflict && (r_conflict_cnt_q != 16'hFFFF)) begin
            w_conflict_cnt_d = r_conflict_cnt_q + 16'd1;
        end
        conflict_count = r_conflict_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt_q <= 16'd0;
        end else begin
            r_conflict_cnt_q <= w_conflict_cnt_d;
        end
    end
`endif

endmodule : mapper_ram_arbiter
`default_nettype wire

// File: doc/mapper_ram_arbiter.md
MAPPER_RAM_ARBITER -- requirements
Module: mapper_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM word width.
REQ-003 SHALL have parameter DEPTH, default 240, number of valid RAM words.
REQ-004 SHALL have parameter MAX_BUS_RUN, default 4, maximum number of consecutive bus grants while the datapath is waiting.
REQ-005 SHALL have these ports, clock and reset first:
  clk  in  1  sole clock
  rst_n  in  1  asynchronous active-low reset
  bus_req  in  1  bus access request
  bus_addr  in  ADDR_W  bus word address
  bus_wdata  in  DATA_W  bus write data
  bus_wen  in  DATA_W/8  byte write enables; all-zero means read
  bus_gnt  out  1  bus access accepted this cycle
  bus_rvalid  out  1  bus read data valid
  bus_rdata  out  DATA_W  bus read data
  bus_err  out  1  out-of-range bus access pulse
  dp_addr_valid  in  1  datapath lookup request
  dp_addr  in  ADDR_W  datapath lookup address
  dp_addr_ready  out  1  datapath lookup accepted
  dp_data_valid  out  1  lookup result valid
  dp_data  out  DATA_W  lookup result
  dp_data_ready  in  1  downstream ready for the lookup result
  ram_en  out  1  RAM access enable
  ram_addr  out  ADDR_W  RAM address
  ram_wdata  out  DATA_W  RAM write data
  ram_wen  out  DATA_W/8  RAM byte write enables
  ram_rdata  in  DATA_W  RAM read data, one-cycle latency

Function
REQ-006 SHALL grant at most one requester per cycle and drive the ram_* outputs combinationally from the winner.
REQ-007 SHALL give the bus priority unless the run counter has reached MAX_BUS_RUN while dp_addr_valid=1 and dp_addr_ready would be 1; in that case the datapath wins.
REQ-008 SHALL increment the run counter on each bus grant made while the datapath is waiting, and clear it on any datapath grant or on any cycle in which the datapath is not waiting.
REQ-009 SHALL assert dp_addr_ready only when the datapath wins and the total of result-buffer occupancy plus in-flight reads is less than 2.
REQ-010 SHALL provide a 2-entry result FIFO with throughput of 1 lookup per cycle when there is no bus contention and dp_data_ready=1.
REQ-011 SHALL have a read latency, from grant to the cycle in which dp_data_valid or bus_rvalid is asserted, of exactly 1 cycle when the FIFO is empty.
REQ-012 SHALL, for a bus read, assert bus_rvalid with bus_rdata one cycle after bus_gnt; a bus write SHALL produce no rvalid.
REQ-013 SHALL, for an address >= DEPTH, grant the access, force ram_en=0, pulse bus_err for a bus access, and return all-zero data for a read.
REQ-014 SHALL hold dp_data stable while dp_data_valid=1 and dp_data_ready=0.
REQ-015 SHALL, on a simultaneous FIFO push and pop, keep occupancy unchanged.

Reset
REQ-016 SHALL clear, on rst_n low, all of the following: the run counter, FIFO occupancy, the in-flight flags, bus_gnt, bus_rvalid, bus_err, dp_data_valid and ram_en; data outputs SHALL reset to 0.
REQ-017 SHALL discard any read in flight when reset is asserted mid-operation; no valid SHALL appear after reset is released.

Configuration
REQ-018 SHALL, when MAPPER_ARB_STATS_EN is defined, add output conflict_count (16 bits): it increments on each cycle in which both requesters are pending and one loses, saturates at 0xFFFF, and resets to 0.
REQ-019 SHALL, when MAPPER_ARB_STATS_EN is not defined, have no conflict_count port and no counter logic.

Structure
REQ-020 SHALL take the DEPTH and address width constants from the shared register-map package; the grant-owner enum (OWNER_NONE, OWNER_BUS, OWNER_DP) SHALL live in a shared package.
REQ-021 SHALL implement the result FIFO as the sub-module mapper_result_fifo.

Verification
REQ-022 Scenario: datapath only, addresses 0..9 back-to-back, dp_data_ready=1 -> 10 results in order with 1-cycle latency and no bubbles.
REQ-023 Scenario: bus_req held continuously with MAX_BUS_RUN=4 and dp_addr_valid=1 -> grant pattern of 4 bus, 1 datapath, repeating.
REQ-024 Scenario: bus write of 0xDEADBEEF to address 5 with bus_wen=0xF, then a datapath read of address 5 -> dp_data=0xDEADBEEF.
REQ-025 Scenario: bus read of address 240 -> bus_gnt=1, ram_en=0, bus_err pulse, bus_rdata=0 on the next cycle.
REQ-026 Scenario: dp_data_ready=0 for 5 cycles -> dp_addr_ready drops after 2 accepted lookups, data held stable, no loss after release.
REQ-027 Scenario: rst_n asserted while a read is in flight -> no dp_data_valid after release, and conflict_count=0 when MAPPER_ARB_STATS_EN is defined.
